// File: rtl/fix_tx_pkg.sv
// Shared constants for the FIX transmit loader: FSM encodings, register map,
// command/status bit positions and the STATUS packing helper.
package fix_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_SEND  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_DATA  = 3'd1;
    localparam logic [2:0] REG_COUNT = 3'd2;
    localparam logic [2:0] REG_DEST  = 3'd3;

    localparam int CMD_START = 0;
    localparam int CMD_CLEAR = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_REJ   = 3;
    localparam int STAT_EMPTY = 4;

    function automatic logic [7:0] pack_status(input logic busy, input logic done,
                                               input logic ovf, input logic rej,
                                               input logic empty);
        logic [7:0] s;
        s             = 8'h00;
        s[STAT_BUSY]  = busy;
        s[STAT_DONE]  = done;
        s[STAT_OVF]   = ovf;
        s[STAT_REJ]   = rej;
        s[STAT_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM with registered read data (one-cycle read latency).
module ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

    // Write port plus registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= data;
        end
        q <= mem_r[addr];
    end

endmodule

// File: rtl/fix_tx_loader.sv
// Host-written FIX message buffer that streams its bytes to the engine over a
// valid/ready handshake once the host issues START.
module fix_tx_loader
    import fix_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            slave_address,
    input  logic                  slave_read,
    output logic [7:0]            slave_readdata,
    input  logic                  slave_write,
    input  logic [DATA_WIDTH-1:0] slave_writedata,
    output logic [DATA_WIDTH-1:0] msg_data,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic                  msg_last,
    output logic                  msg_dest,
    output logic                  msg_done
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    state_t                state_r;
    logic [CNT_W-1:0]      count_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic                  dest_r;
    logic                  done_flag_r;
    logic                  ovf_r;
    logic                  rej_r;

    logic                  busy_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  last_s;
    logic                  ctrl_wr_s;
    logic                  data_wr_s;
    logic                  dest_wr_s;
    logic                  start_s;
    logic                  clear_s;
    logic                  ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_q_s;

    assign busy_s    = (state_r != ST_IDLE);
    assign empty_s   = (count_r == CNT_ZERO);
    assign full_s    = (count_r == CNT_FULL);
    assign last_s    = ({1'b0, rd_ptr_r} == (count_r - CNT_ONE));
    assign ctrl_wr_s = slave_write && (slave_address == REG_CTRL);
    assign data_wr_s = slave_write && (slave_address == REG_DATA);
    assign dest_wr_s = slave_write && (slave_address == REG_DEST);
    assign start_s   = ctrl_wr_s && slave_writedata[CMD_START];
    assign clear_s   = ctrl_wr_s && slave_writedata[CMD_CLEAR];

    // Writes are barred while busy, so the single RAM port never contends.
    assign ram_we_s   = data_wr_s && !busy_s && !full_s && !reset;
    assign ram_addr_s = busy_s ? rd_ptr_r : wr_ptr_r;

    ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) buffer (
        .clk (clk),
        .we  (ram_we_s),
        .data(slave_writedata),
        .addr(ram_addr_s),
        .q   (ram_q_s)
    );

    // Buffer bookkeeping, sticky flags and the streaming FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= CNT_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            dest_r      <= 1'b0;
            done_flag_r <= 1'b0;
            ovf_r       <= 1'b0;
            rej_r       <= 1'b0;
            msg_data    <= DATA_WIDTH'(0);
            msg_valid   <= 1'b0;
            msg_last    <= 1'b0;
            msg_dest    <= 1'b0;
            msg_done    <= 1'b0;
        end else if (clear_s) begin
            state_r     <= ST_IDLE;
            count_r     <= CNT_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            done_flag_r <= 1'b0;
            ovf_r       <= 1'b0;
            rej_r       <= 1'b0;
            msg_valid   <= 1'b0;
            msg_last    <= 1'b0;
            msg_done    <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (dest_wr_s) begin
                if (busy_s) rej_r  <= 1'b1;
                else        dest_r <= slave_writedata[0];
            end
            if (data_wr_s) begin
                if (busy_s) begin
                    rej_r <= 1'b1;
                end else if (full_s) begin
                    ovf_r <= 1'b1;
                end else begin
                    count_r  <= count_r + CNT_ONE;
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
            end
            if (start_s && busy_s) begin
                rej_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s && !empty_s) begin
                        msg_dest    <= dest_r;
                        done_flag_r <= 1'b0;
                        rd_ptr_r    <= PTR_ZERO;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_FETCH: state_r <= ST_WAIT;
                ST_WAIT: begin
                    msg_data  <= ram_q_s;
                    msg_last  <= last_s;
                    msg_valid <= 1'b1;
                    state_r   <= ST_SEND;
                end
                ST_SEND: begin
                    if (msg_ready) begin
                        msg_valid <= 1'b0;
                        msg_last  <= 1'b0;
                        if (last_s) begin
                            msg_done <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            rd_ptr_r <= rd_ptr_r + PTR_ONE;
                            state_r  <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_flag_r <= 1'b1;
                    count_r     <= CNT_ZERO;
                    wr_ptr_r    <= PTR_ZERO;
                    state_r     <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Registered read data: STATUS/COUNT/DEST as seen at the read edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            slave_readdata <= 8'h00;
        end else if (slave_read) begin
            case (slave_address)
                REG_CTRL:  slave_readdata <= pack_status(busy_s, done_flag_r, ovf_r, rej_r, empty_s);
                REG_COUNT: slave_readdata <= 8'(count_r);
                REG_DEST:  slave_readdata <= {7'b0000000, dest_r};
                default:   slave_readdata <= 8'h00;
            endcase
        end else begin
            slave_readdata <= 8'h00;
        end
    end

endmodule
